// File: rtl/mdu_hilo.sv
// Iterative multiply/divide unit with HI/LO result registers for the EX stage.
// One shift-add (MULT/MULTU) or restoring-divide (DIV/DIVU) step per cycle, then a sign fix-up.
module mdu_hilo #(
  parameter int unsigned W     = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  input  logic [1:0]   op,
  input  logic         start,
  input  logic         mthi,
  input  logic         mtlo,
  output logic [W-1:0] hi,
  output logic [W-1:0] lo,
  output logic         busy,
  output logic         done,
  output logic         div0
);

  typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       op_q, op_d;
  logic             sign_a_q, sign_a_d;
  logic             sign_b_q, sign_b_d;
  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     b_mag_q, b_mag_d;
  logic [2*W-1:0]   acc_q, acc_d;
  logic [W-1:0]     hi_q, hi_d;
  logic [W-1:0]     lo_q, lo_d;
  logic             div0_q, div0_d;

  logic             in_sign_a, in_sign_b;
  logic [W-1:0]     a_abs, b_abs;
  logic             is_div, is_signed;
  logic [W:0]       mul_sum;
  logic [2*W-1:0]   mul_step;
  logic [W:0]       rem_sh, trial;
  logic             no_borrow;
  logic [2*W-1:0]   div_step;
  logic [2*W-1:0]   prod_neg;
  logic [W-1:0]     quo, rem, quo_neg, rem_neg;

  assign in_sign_a = op[0] & A[W-1];
  assign in_sign_b = op[0] & B[W-1];
  assign a_abs     = in_sign_a ? -A : A;
  assign b_abs     = in_sign_b ? -B : B;

  assign is_div    = op_q[1];
  assign is_signed = op_q[0];

  // Multiply: acc = {partial product, remaining multiplier bits}; add then shift right.
  assign mul_sum  = {1'b0, acc_q[2*W-1:W]} + {1'b0, b_mag_q};
  assign mul_step = acc_q[0] ? {mul_sum, acc_q[W-1:1]} : {1'b0, acc_q[2*W-1:1]};

  // Divide: acc = {partial remainder, dividend bits shifting out / quotient bits shifting in}.
  assign rem_sh    = acc_q[2*W-1:W-1];
  assign trial     = rem_sh - {1'b0, b_mag_q};
  assign no_borrow = rem_sh >= {1'b0, b_mag_q};
  assign div_step  = no_borrow ? {trial[W-1:0], acc_q[W-2:0], 1'b1}
                               : {acc_q[2*W-2:0], 1'b0};

  assign prod_neg = -acc_q;
  assign quo      = acc_q[W-1:0];
  assign rem      = acc_q[2*W-1:W];
  assign quo_neg  = -quo;
  assign rem_neg  = -rem;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    a_d      = a_q;
    b_mag_d  = b_mag_q;
    acc_d    = acc_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    div0_d   = div0_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d  = StCalc;
          cnt_d    = '0;
          op_d     = op;
          sign_a_d = in_sign_a;
          sign_b_d = in_sign_b;
          a_d      = A;
          b_mag_d  = b_abs;
          acc_d    = {{W{1'b0}}, a_abs};
          div0_d   = 1'b0;
        end else begin
          if (mthi) hi_d = A;
          if (mtlo) lo_d = A;
        end
      end
      StCalc: begin
        cnt_d = cnt_q + 1'b1;
        acc_d = is_div ? div_step : mul_step;
        if (cnt_q == CNT_W'(W - 1)) state_d = StFix;
      end
      StFix: begin
        state_d = StDone;
        if (is_div) begin
          if (b_mag_q == '0) begin
            hi_d   = a_q;
            lo_d   = '1;
            div0_d = 1'b1;
          end else begin
            lo_d = (is_signed & (sign_a_q ^ sign_b_q)) ? quo_neg : quo;
            hi_d = (is_signed & sign_a_q) ? rem_neg : rem;
          end
        end else begin
          {hi_d, lo_d} = (is_signed & (sign_a_q ^ sign_b_q)) ? prod_neg : acc_q;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      op_q     <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      a_q      <= '0;
      b_mag_q  <= '0;
      acc_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      div0_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      a_q      <= a_d;
      b_mag_q  <= b_mag_d;
      acc_q    <= acc_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      div0_q   <= div0_d;
    end
  end

  assign hi   = hi_q;
  assign lo   = lo_q;
  assign div0 = div0_q;
  assign busy = (state_q != StIdle);
  assign done = (state_q == StDone);

endmodule

// File: tb/tb_mdu_hilo.sv
// Self-checking bench for mdu_hilo: directed corner cases plus randomized ops
// compared against a 64-bit arithmetic reference model.
module tb_mdu_hilo;
  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [1:0]   op = '0;
  logic         start = 1'b0;
  logic         mthi = 1'b0;
  logic         mtlo = 1'b0;
  logic [W-1:0] hi, lo;
  logic         busy, done, div0;

  int           checks = 0;
  int           failures = 0;
  logic [W-1:0] ref_hi = '0;
  logic [W-1:0] ref_lo = '0;
  logic         ref_div0 = 1'b0;
  int           n;

  mdu_hilo #(.W(W), .CNT_W(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .A     (a),
    .B     (b),
    .op    (op),
    .start (start),
    .mthi  (mthi),
    .mtlo  (mtlo),
    .hi    (hi),
    .lo    (lo),
    .busy  (busy),
    .done  (done),
    .div0  (div0)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain wide arithmetic, C-style truncating signed division.
  task automatic model(input logic [1:0] o, input logic [W-1:0] ra, input logic [W-1:0] rb,
                       output logic [W-1:0] eh, output logic [W-1:0] el, output logic ed);
    longint      sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(ra));
    sb = longint'($signed(rb));
    ed = 1'b0;
    eh = '0;
    el = '0;
    case (o)
      2'b00: begin p = {32'b0, ra} * {32'b0, rb}; {eh, el} = p; end
      2'b01: begin p = 64'(sa * sb); {eh, el} = p; end
      default: begin
        if (rb == '0) begin
          eh = ra;
          el = '1;
          ed = 1'b1;
        end else if (o == 2'b10) begin
          el = ra / rb;
          eh = ra % rb;
        end else begin
          q  = sa / sb;
          r  = sa % sb;
          el = 32'(q);
          eh = 32'(r);
        end
      end
    endcase
  endtask

  task automatic run_op(input logic [1:0] o, input logic [W-1:0] ra, input logic [W-1:0] rb,
                        input string tag);
    logic [W-1:0] eh, el;
    logic         ed;
    int           lat, bcnt;
    model(o, ra, rb, eh, el, ed);
    op = o; a = ra; b = rb; start = 1'b1;
    @(negedge clk);
    start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    a = $urandom; b = $urandom; op = 2'($urandom);
    lat = 0;
    bcnt = 0;
    while (!done && lat < 100) begin
      if (busy) bcnt++;
      if (lat == 10) begin
        check({tag, "_hold_hi"}, hi, ref_hi);
        check({tag, "_hold_lo"}, lo, ref_lo);
      end
      @(negedge clk);
      lat++;
    end
    if (busy) bcnt++;
    check({tag, "_latency"}, lat, W + 1);
    check({tag, "_hi"}, hi, eh);
    check({tag, "_lo"}, lo, el);
    check({tag, "_div0"}, div0, ed);
    ref_hi = eh;
    ref_lo = el;
    ref_div0 = ed;
    @(negedge clk);
    check({tag, "_done_pulse"}, done, 0);
    check({tag, "_idle"}, busy, 0);
    check({tag, "_busy_cycles"}, bcnt, W + 2);
  endtask

  initial begin
    @(negedge clk);
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_div0", div0, 0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(2'b00, 32'hffffffff, 32'hffffffff, "t1_multu");
    run_op(2'b01, 32'hfffffffd, 32'h00000007, "t2_mult");
    run_op(2'b11, 32'hfffffff9, 32'h00000002, "t3_div");
    run_op(2'b11, 32'h80000000, 32'hffffffff, "t3_div_wrap");
    run_op(2'b10, 32'h12345678, 32'h00000000, "t4_divu0");
    run_op(2'b10, 32'd100, 32'd7, "t4_divu");
    run_op(2'b11, 32'h80000000, 32'h00000000, "div_by0");

    // Start/mthi/mtlo while busy must all be ignored.
    op = 2'b00; a = 32'd2; b = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    start = 1'b1; op = 2'b10; a = 32'd9; b = 32'd3; mthi = 1'b1;
    @(negedge clk);
    start = 1'b0; mthi = 1'b0; mtlo = 1'b1; a = 32'hdeadbeef;
    @(negedge clk);
    mtlo = 1'b0;
    check("t5_busy", busy, 1);
    check("t5_hold_hi", hi, ref_hi);
    check("t5_hold_lo", lo, ref_lo);
    n = 0;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("t5_done_seen", done, 1);
    check("t5_hi", hi, 0);
    check("t5_lo", lo, 6);
    ref_hi = '0;
    ref_lo = 32'd6;
    @(negedge clk);
    check("t5_back_idle", busy, 0);
    mtlo = 1'b1; a = 32'h55;
    @(negedge clk);
    mtlo = 1'b0;
    check("t5_mtlo_lo", lo, 32'h55);
    check("t5_mtlo_hi", hi, 0);
    mthi = 1'b1; mtlo = 1'b1; a = 32'ha5a5a5a5;
    @(negedge clk);
    mthi = 1'b0; mtlo = 1'b0;
    check("mt_both_hi", hi, 32'ha5a5a5a5);
    check("mt_both_lo", lo, 32'ha5a5a5a5);
    ref_hi = 32'ha5a5a5a5;
    ref_lo = 32'ha5a5a5a5;
    mthi = 1'b1;
    run_op(2'b00, 32'd3, 32'd5, "start_prio");

    // Asynchronous reset in the middle of a divide.
    op = 2'b11; a = 32'hfffffff9; b = 32'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_hi", hi, 0);
    check("t6_rst_lo", lo, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_done", done, 0);
    check("t6_rst_div0", div0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    ref_hi = '0;
    ref_lo = '0;
    ref_div0 = 1'b0;
    @(negedge clk);
    run_op(2'b00, 32'd4, 32'd5, "t6_multu");

    for (int i = 0; i < 16; i++) begin
      logic [1:0]   ro;
      logic [W-1:0] ra, rb;
      ro = 2'($urandom);
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 5))
        0: rb = '0;
        1: rb = '1;
        2: ra = 32'h80000000;
        3: rb = 32'($urandom_range(1, 15));
        default: ;
      endcase
      run_op(ro, ra, rb, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
